// File: rtl/cpu_control_fsm_pkg.sv
// Shared constants for the multi-cycle RV32I control unit: ALU codes, mux selects, opcodes, states.
// The optional ANDN decode is enabled with CPU_ZBB_ANDN_EN (see cpu_alu_decoder).
package cpu_control_fsm_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned IMM_SEL_W  = 3;
  localparam int unsigned STATE_W    = 4;
  localparam int unsigned OPC_W      = 7;
  localparam int unsigned F3_W       = 3;
  localparam int unsigned F7_W       = 7;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD     = 4'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB     = 4'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL     = 4'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT     = 4'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU    = 4'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR     = 4'd5;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL     = 4'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA     = 4'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR      = 4'd8;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND     = 4'd9;
  localparam logic [ALU_CTRL_W-1:0] ALU_PASS_B  = 4'd10;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND_NOT = 4'd11;

  localparam logic [SEL_W-1:0] SRC_A_PC     = 2'd0;
  localparam logic [SEL_W-1:0] SRC_A_OLD_PC = 2'd1;
  localparam logic [SEL_W-1:0] SRC_A_RS1    = 2'd2;
  localparam logic [SEL_W-1:0] SRC_B_RS2    = 2'd0;
  localparam logic [SEL_W-1:0] SRC_B_IMM    = 2'd1;
  localparam logic [SEL_W-1:0] SRC_B_FOUR   = 2'd2;
  localparam logic [SEL_W-1:0] RES_ALU_OUT  = 2'd0;
  localparam logic [SEL_W-1:0] RES_MEM_DATA = 2'd1;
  localparam logic [SEL_W-1:0] RES_ALU      = 2'd2;

  localparam logic [IMM_SEL_W-1:0] IMM_I = 3'd0;
  localparam logic [IMM_SEL_W-1:0] IMM_S = 3'd1;
  localparam logic [IMM_SEL_W-1:0] IMM_B = 3'd2;
  localparam logic [IMM_SEL_W-1:0] IMM_U = 3'd3;
  localparam logic [IMM_SEL_W-1:0] IMM_J = 3'd4;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [F7_W-1:0] F7_BASE = 7'h00;
  localparam logic [F7_W-1:0] F7_ALT  = 7'h20;

  typedef enum logic [STATE_W-1:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R,
    S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_ILLEGAL, S_HALT
  } state_t;

  // Immediate format used by the OLD_PC+IMM target computation in DECODE
  function automatic logic [IMM_SEL_W-1:0] imm_sel_for(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_STORE:           imm_sel_for = IMM_S;
      OPC_BRANCH:          imm_sel_for = IMM_B;
      OPC_LUI, OPC_AUIPC:  imm_sel_for = IMM_U;
      OPC_JAL:             imm_sel_for = IMM_J;
      default:             imm_sel_for = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/cpu_control_fsm_alu_decoder.sv
// Combinational opcode/funct3/funct7 -> ALU code and illegal-encoding decode.
// CPU_ZBB_ANDN_EN adds OP funct7=0x20 funct3=111 as ANDN; otherwise that encoding is illegal.
module cpu_alu_decoder
  import cpu_control_fsm_pkg::*;
(
  input  logic [OPC_W-1:0]      opcode,
  input  logic [F3_W-1:0]       funct3,
  input  logic [F7_W-1:0]       funct7,
  output logic [ALU_CTRL_W-1:0] alu_control_c,
  output logic                  illegal_c
);

  function automatic logic [ALU_CTRL_W-1:0] base_op(input logic [F3_W-1:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    alu_control_c = ALU_ADD;
    illegal_c     = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_control_c = base_op(funct3);
        if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  alu_control_c = ALU_SUB;
            3'b101:  alu_control_c = ALU_SRA;
`ifdef CPU_ZBB_ANDN_EN
            3'b111:  alu_control_c = ALU_AND_NOT;
`endif
            default: illegal_c = 1'b1;
          endcase
        end else if (funct7 != F7_BASE) begin
          illegal_c = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        alu_control_c = base_op(funct3);
        // Only shift immediates carry a funct7; other OP-IMM funct7 bits are immediate
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          if (funct7 != F7_BASE && funct7 != F7_ALT) begin
            illegal_c = 1'b1;
          end else if (funct3 == 3'b101 && funct7[5]) begin
            alu_control_c = ALU_SRA;
          end
        end
      end
      OPC_BRANCH: begin
        alu_control_c = ALU_SUB;
        illegal_c     = (funct3[2:1] == 2'b01);
      end
      OPC_LUI:                                            alu_control_c = ALU_PASS_B;
      OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_AUIPC: alu_control_c = ALU_ADD;
      default:                                            illegal_c     = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle RV32I control FSM driving the cpu_alu datapath muxes and the memory handshake.
// Define CPU_ZBB_ANDN_EN to accept ANDN; HALT_ON_ILLEGAL selects halt vs. pulse-and-refetch.
module cpu_control_fsm
  import cpu_control_fsm_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [XLEN-1:0]       instr,
  input  logic                  zero,
  input  logic                  neg,
  input  logic                  carry,
  input  logic                  overflow,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_addr_sel,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [SEL_W-1:0]      alu_src_a_sel,
  output logic [SEL_W-1:0]      alu_src_b_sel,
  output logic [SEL_W-1:0]      result_sel,
  output logic [IMM_SEL_W-1:0]  imm_sel,
  output logic                  illegal,
  output logic [STATE_W-1:0]    state
);

  state_t                  state_q, state_d;
  logic [OPC_W-1:0]        opcode;
  logic [F3_W-1:0]         funct3;
  logic [F7_W-1:0]         funct7;
  logic [ALU_CTRL_W-1:0]   dec_alu;
  logic                    dec_illegal;
  logic                    taken;
  logic                    unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7       = instr[31:25];
  assign unused_instr = ^{instr[24:15], instr[11:7]};
  assign state        = state_q;

  cpu_alu_decoder u_alu_decoder (
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .alu_control_c (dec_alu),
    .illegal_c     (dec_illegal)
  );

  // Branch resolution from the flags of RS1-RS2 (carry set means no borrow)
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = neg ^ overflow;
      3'b101:  taken = !(neg ^ overflow);
      3'b110:  taken = !carry;
      3'b111:  taken = carry;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_control   = ALU_ADD;
    alu_src_a_sel = SRC_A_PC;
    alu_src_b_sel = SRC_B_RS2;
    result_sel    = RES_ALU_OUT;
    imm_sel       = IMM_I;
    illegal       = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_req       = 1'b1;
        alu_src_b_sel = SRC_B_FOUR;
        result_sel    = RES_ALU;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a_sel = SRC_A_OLD_PC;
        alu_src_b_sel = SRC_B_IMM;
        imm_sel       = imm_sel_for(opcode);
        if (dec_illegal) begin
          state_d = S_ILLEGAL;
        end else begin
          case (opcode)
            OPC_LOAD, OPC_STORE:  state_d = S_MEMADR;
            OPC_OP:               state_d = S_EXEC_R;
            OPC_OP_IMM, OPC_JALR: state_d = S_EXEC_I;
            OPC_BRANCH:           state_d = S_BRANCH;
            OPC_JAL:              state_d = S_JAL;
            OPC_LUI:              state_d = S_LUI;
            OPC_AUIPC:            state_d = S_ALU_WB;
            default:              state_d = S_ILLEGAL;
          endcase
        end
      end
      S_EXEC_R: begin
        alu_control   = dec_alu;
        alu_src_a_sel = SRC_A_RS1;
        state_d       = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_control   = dec_alu;
        alu_src_a_sel = SRC_A_RS1;
        alu_src_b_sel = SRC_B_IMM;
        state_d       = (opcode == OPC_JALR) ? S_JALR : S_ALU_WB;
      end
      S_MEMADR: begin
        alu_src_a_sel = SRC_A_RS1;
        alu_src_b_sel = SRC_B_IMM;
        imm_sel       = (opcode == OPC_STORE) ? IMM_S : IMM_I;
        state_d       = (opcode == OPC_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_sel = RES_MEM_DATA;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_control   = ALU_SUB;
        alu_src_a_sel = SRC_A_RS1;
        imm_sel       = IMM_B;
        pc_write      = taken;
        state_d       = S_FETCH;
      end
      // Jump target already sits in ALU_OUT; the ALU forms the link value OLD_PC+4
      S_JAL, S_JALR: begin
        pc_write      = 1'b1;
        alu_src_a_sel = SRC_A_OLD_PC;
        alu_src_b_sel = SRC_B_FOUR;
        state_d       = S_ALU_WB;
      end
      S_LUI: begin
        alu_control   = ALU_PASS_B;
        alu_src_b_sel = SRC_B_IMM;
        imm_sel       = IMM_U;
        state_d       = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
      end
      S_HALT:  illegal = 1'b1;
      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: a halting and a non-halting instance share stimulus,
// expectations go through a scoreboard queue. Honours CPU_ZBB_ANDN_EN.
`timescale 1ns/1ps
module tb_cpu_control_fsm;
  import cpu_control_fsm_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic [6:0] ctl;   // req we addr_sel ir_write pc_write reg_write illegal
    logic [3:0] alu;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] res;
    logic [2:0] imm;
  } snap_t;

  typedef struct {
    int    tgt;        // 0: halting instance, 1: pulsing instance
    string tag;
    snap_t val;
    snap_t care;
  } exp_t;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_BLTU = 32'h0020E463;
  localparam logic [31:0] I_LW   = 32'h0000A283;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_ANDN = 32'h40007033;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_REQ   = 7'b1000000;
  localparam logic [6:0] C_FETCH = 7'b1001100;
  localparam logic [6:0] C_RD    = 7'b1010000;
  localparam logic [6:0] C_WR    = 7'b1110000;
  localparam logic [6:0] C_PCW   = 7'b0000100;
  localparam logic [6:0] C_RW    = 7'b0000010;
  localparam logic [6:0] C_ILL   = 7'b0000001;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic zero = 1'b0, neg = 1'b0, carry = 1'b0, overflow = 1'b0, mem_ready = 1'b0;

  logic req_h, we_h, asel_h, irw_h, pcw_h, rw_h, ill_h;
  logic [3:0] alu_h, st_h;
  logic [1:0] a_h, b_h, res_h;
  logic [2:0] imm_h;
  logic req_l, we_l, asel_l, irw_l, pcw_l, rw_l, ill_l;
  logic [3:0] alu_l, st_l;
  logic [1:0] a_l, b_l, res_l;
  logic [2:0] imm_l;
  snap_t snap_h, snap_l;

  exp_t sb[$];
  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  cpu_control_fsm #(.HALT_ON_ILLEGAL(1'b1)) dut_halt (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .neg(neg), .carry(carry),
    .overflow(overflow), .mem_ready(mem_ready), .mem_req(req_h), .mem_we(we_h),
    .mem_addr_sel(asel_h), .ir_write(irw_h), .pc_write(pcw_h), .reg_write(rw_h),
    .alu_control(alu_h), .alu_src_a_sel(a_h), .alu_src_b_sel(b_h), .result_sel(res_h),
    .imm_sel(imm_h), .illegal(ill_h), .state(st_h)
  );

  cpu_control_fsm #(.HALT_ON_ILLEGAL(1'b0)) dut_pulse (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .neg(neg), .carry(carry),
    .overflow(overflow), .mem_ready(mem_ready), .mem_req(req_l), .mem_we(we_l),
    .mem_addr_sel(asel_l), .ir_write(irw_l), .pc_write(pcw_l), .reg_write(rw_l),
    .alu_control(alu_l), .alu_src_a_sel(a_l), .alu_src_b_sel(b_l), .result_sel(res_l),
    .imm_sel(imm_l), .illegal(ill_l), .state(st_l)
  );

  assign snap_h = {st_h, req_h, we_h, asel_h, irw_h, pcw_h, rw_h, ill_h, alu_h, a_h, b_h, res_h, imm_h};
  assign snap_l = {st_l, req_l, we_l, asel_l, irw_l, pcw_l, rw_l, ill_l, alu_l, a_l, b_l, res_l, imm_l};

  // tgt: bit0 halting instance, bit1 pulsing instance; mc: care bits for alu,a,b,res,imm
  task automatic push(input logic [1:0] tgt, input string tag, input logic [3:0] st,
                      input logic [6:0] ctl, input logic [3:0] alu, input logic [1:0] a,
                      input logic [1:0] b, input logic [1:0] res, input logic [2:0] imm,
                      input logic [4:0] mc);
    exp_t e;
    e.tag  = tag;
    e.val  = {st, ctl, alu, a, b, res, imm};
    e.care = {4'hF, 7'h7F, {4{mc[4]}}, {2{mc[3]}}, {2{mc[2]}}, {2{mc[1]}}, {3{mc[0]}}};
    for (int t = 0; t < 2; t++) begin
      if (tgt[t]) begin
        e.tgt = t;
        sb.push_back(e);
      end
    end
  endtask

  task automatic e_reset(input logic [1:0] tgt, input string tag);
    push(tgt, tag, S_RESET, C_NONE, ALU_ADD, 2'd0, 2'd0, 2'd0, 3'd0, 5'b11111);
  endtask

  task automatic e_fetch(input logic [1:0] tgt, input string tag, input logic rdy);
    push(tgt, tag, S_FETCH, rdy ? C_FETCH : C_REQ, ALU_ADD, SRC_A_PC, SRC_B_FOUR, RES_ALU,
         3'd0, 5'b11110);
  endtask

  task automatic e_decode(input string tag, input logic [2:0] imm, input logic chk_imm);
    push(2'b11, tag, S_DECODE, C_NONE, ALU_ADD, SRC_A_OLD_PC, SRC_B_IMM, 2'd0, imm,
         {4'b1110, chk_imm});
  endtask

  task automatic step(input logic [31:0] i, input logic rdy);
    @(negedge clk);
    instr     = i;
    mem_ready = rdy;
  endtask

  // ALU flag model for RS1-RS2
  task automatic set_flags(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] d;
    d        = x - y;
    zero     = (d == 32'd0);
    neg      = d[31];
    carry    = (x >= y);
    overflow = (x[31] != y[31]) && (d[31] != x[31]);
  endtask

  task automatic check();
    exp_t  e;
    snap_t o;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = (e.tgt == 0) ? snap_h : snap_l;
      nvec++;
      assert ((o & e.care) === (e.val & e.care)) else begin
        nmis++;
        $error("FAIL %s (dut %0d): observed %h required %h care %h", e.tag, e.tgt, o, e.val, e.care);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);

    step(32'd0, 1'b0); rst_n = 1'b1;
    e_reset(2'b11, "reset_state"); check();
    for (int k = 0; k < 3; k++) begin
      step(32'd0, 1'b0); e_fetch(2'b11, "fetch_wait", 1'b0); check();
    end

    step(I_ADD, 1'b1); e_fetch(2'b11, "add_fetch", 1'b1); check();
    step(I_ADD, 1'b1); e_decode("add_decode", IMM_I, 1'b0); check();
    step(I_ADD, 1'b0);
    push(2'b11, "add_exec", S_EXEC_R, C_NONE, ALU_ADD, SRC_A_RS1, SRC_B_RS2, 2'd0, 3'd0, 5'b11100);
    check();
    step(I_ADD, 1'b0);
    push(2'b11, "add_wb", S_ALU_WB, C_RW, ALU_ADD, 2'd0, 2'd0, RES_ALU_OUT, 3'd0, 5'b00010);
    check();

    for (int k = 0; k < 2; k++) begin
      step(I_BLTU, 1'b1); e_fetch(2'b11, "bltu_fetch", 1'b1); check();
      step(I_BLTU, 1'b0); e_decode("bltu_decode", IMM_B, 1'b1); check();
      step(I_BLTU, 1'b0);
      if (k == 0) set_flags(32'd1, 32'd2);
      else        set_flags(32'd2, 32'd1);
      push(2'b11, (k == 0) ? "bltu_taken" : "bltu_not_taken", S_BRANCH, (k == 0) ? C_PCW : C_NONE,
           ALU_SUB, SRC_A_RS1, SRC_B_RS2, RES_ALU_OUT, 3'd0, 5'b11110);
      check();
    end

    step(I_LW, 1'b1); e_fetch(2'b11, "lw_fetch", 1'b1); check();
    step(I_LW, 1'b0); e_decode("lw_decode", IMM_I, 1'b1); check();
    step(I_LW, 1'b1);
    push(2'b11, "lw_memadr", S_MEMADR, C_NONE, ALU_ADD, SRC_A_RS1, SRC_B_IMM, 2'd0, IMM_I, 5'b11101);
    check();
    for (int k = 0; k < 3; k++) begin
      step(I_LW, (k == 2));
      push(2'b11, "lw_memrd", S_MEMRD, C_RD, 4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 5'b00000);
      check();
    end
    step(I_LW, 1'b1);
    push(2'b11, "lw_memwb", S_MEMWB, C_RW, 4'd0, 2'd0, 2'd0, RES_MEM_DATA, 3'd0, 5'b00010);
    check();
    step(I_ANDN, 1'b0); e_fetch(2'b11, "lw_done_fetch", 1'b0); check();

    step(I_ANDN, 1'b1); e_fetch(2'b11, "andn_fetch", 1'b1); check();
`ifdef CPU_ZBB_ANDN_EN
    step(I_ANDN, 1'b0); e_decode("andn_decode", IMM_I, 1'b0); check();
    step(I_ANDN, 1'b0);
    push(2'b11, "andn_exec", S_EXEC_R, C_NONE, ALU_AND_NOT, SRC_A_RS1, SRC_B_RS2, 2'd0, 3'd0, 5'b11100);
    check();
    step(I_ANDN, 1'b0);
    push(2'b11, "andn_wb", S_ALU_WB, C_RW, 4'd0, 2'd0, 2'd0, RES_ALU_OUT, 3'd0, 5'b00010);
    check();
    step(I_BAD, 1'b1); e_fetch(2'b11, "bad_fetch", 1'b1); check();
    step(I_BAD, 1'b0);
    push(2'b11, "bad_decode", S_DECODE, C_NONE, 4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 5'b00000);
    check();
`else
    step(I_ANDN, 1'b0); e_decode("andn_decode", IMM_I, 1'b0); check();
`endif
    step(instr, 1'b0);
    push(2'b11, "illegal_pulse", S_ILLEGAL, C_ILL, 4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 5'b00000);
    check();
    for (int k = 0; k < 3; k++) begin
      step(instr, (k == 1));
      push(2'b01, "halt_sticky", S_HALT, C_ILL, 4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 5'b11111);
      if (k < 2) e_fetch(2'b10, "refetch_after_illegal", (k == 1));
      check();
    end

    step(32'd0, 1'b0); rst_n = 1'b0;
    e_reset(2'b11, "reset_from_halt"); check();
    step(I_SW, 1'b1);
    e_reset(2'b11, "reset_hold"); check();
    step(I_SW, 1'b1); rst_n = 1'b1;
    e_reset(2'b11, "reset_release"); check();
    step(I_SW, 1'b1); e_fetch(2'b11, "sw_fetch", 1'b1); check();
    step(I_SW, 1'b0); e_decode("sw_decode", IMM_S, 1'b1); check();
    step(I_SW, 1'b1);
    push(2'b11, "sw_memadr", S_MEMADR, C_NONE, ALU_ADD, SRC_A_RS1, SRC_B_IMM, 2'd0, IMM_S, 5'b11101);
    check();
    for (int k = 0; k < 2; k++) begin
      step(I_SW, 1'b0);
      push(2'b11, "sw_memwr_wait", S_MEMWR, C_WR, 4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 5'b00000);
      check();
    end
    #1 rst_n = 1'b0;
    e_reset(2'b11, "reset_mid_store"); check();
    step(I_SW, 1'b1);
    e_reset(2'b11, "reset_no_strobes"); check();
    step(I_SW, 1'b1); rst_n = 1'b1;
    e_reset(2'b11, "reset_release2"); check();
    for (int k = 0; k < 2; k++) begin
      step(32'd0, 1'b0); e_fetch(2'b11, "post_reset_fetch", 1'b0); check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
